// File: rtl/ccr_unit.sv
// Condition code register: holds the {V,C,N,Z} flags, applies ALU updates and
// jump-taken clears, and saves/restores flags through a LIFO for nested interrupts.
module ccr_unit #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          z_en,
    input  logic          n_en,
    input  logic          c_en,
    input  logic          v_en,
    input  logic          alu_z,
    input  logic          alu_n,
    input  logic          alu_c,
    input  logic          alu_v,
    input  logic          jz_taken,
    input  logic          jn_taken,
    input  logic          jc_taken,
    input  logic          jv_taken,
    input  logic          int_save,
    input  logic          rti_restore,
    output logic [3:0]    flags,
    output logic [CW-1:0] depth_count,
    output logic          stack_full,
    output logic          stack_empty,
    output logic          ovf_err,
    output logic          unf_err
);

    // Per-bit update then clear; a taken jump's clear wins over a same-cycle load.
    function automatic logic [3:0] next_flags(
        input logic [3:0] cur,
        input logic [3:0] en,
        input logic [3:0] alu,
        input logic [3:0] clr
    );
        logic [3:0] upd;
        upd = (en & alu) | (~en & cur);
        return upd & ~clr;
    endfunction

    logic [3:0]    flags_r;
    logic [3:0]    stack_r [0:DEPTH-1];
    logic [CW-1:0] depth_r;
    logic          ovf_r;
    logic          unf_r;

    logic [3:0]    en_s;
    logic [3:0]    alu_s;
    logic [3:0]    clr_s;
    logic [3:0]    norm_s;
    logic [3:0]    top_s;
    logic [3:0]    flags_nxt_s;
    logic [CW-1:0] depth_nxt_s;
    logic          full_s;
    logic          empty_s;
    logic          push_req_s;
    logic          pop_req_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign en_s       = {v_en, c_en, n_en, z_en};
    assign alu_s      = {alu_v, alu_c, alu_n, alu_z};
    assign clr_s      = {jv_taken, jc_taken, jn_taken, jz_taken};
    assign norm_s     = next_flags(flags_r, en_s, alu_s, clr_s);
    assign full_s     = (depth_r == CW'(DEPTH));
    assign empty_s    = (depth_r == CW'(0));
    // Simultaneous save and restore cancel each other: no stack op, no error.
    assign push_req_s = int_save & ~rti_restore;
    assign pop_req_s  = rti_restore & ~int_save;
    assign push_ok_s  = push_req_s & ~full_s;
    assign pop_ok_s   = pop_req_s & ~empty_s;

    // Select the top-of-stack entry (index depth-1) without a wide array index.
    always_comb begin
        top_s = 4'b0000;
        for (int i = 0; i < DEPTH; i++) begin
            top_s = (depth_r == CW'(i + 1)) ? stack_r[i] : top_s;
        end
    end

    // Next flag value and next stack occupancy.
    always_comb begin
        flags_nxt_s = norm_s;
        depth_nxt_s = depth_r;
        if (pop_ok_s) begin
            flags_nxt_s = top_s;
            depth_nxt_s = depth_r - CW'(1);
        end else if (push_ok_s) begin
            flags_nxt_s = norm_s;
            depth_nxt_s = depth_r + CW'(1);
        end else begin
            flags_nxt_s = norm_s;
            depth_nxt_s = depth_r;
        end
    end

    // State registers: reset wins over stall; stall freezes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= 4'b0000;
            depth_r <= CW'(0);
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= 4'b0000;
            end
        end else if (!stall) begin
            flags_r <= flags_nxt_s;
            depth_r <= depth_nxt_s;
            ovf_r   <= ovf_r | (push_req_s & full_s);
            unf_r   <= unf_r | (pop_req_s & empty_s);
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok_s && (depth_r == CW'(i))) begin
                    stack_r[i] <= norm_s;
                end
            end
        end
    end

    assign flags       = flags_r;
    assign depth_count = depth_r;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign ovf_err     = ovf_r;
    assign unf_err     = unf_r;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed-vector bench for ccr_unit: the driver queues hand-computed expected
// state per cycle, a monitor pops and compares after each clock edge.
module tb_ccr_unit;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          z_en = 1'b0, n_en = 1'b0, c_en = 1'b0, v_en = 1'b0;
    logic          alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic          jz_taken = 1'b0, jn_taken = 1'b0, jc_taken = 1'b0, jv_taken = 1'b0;
    logic          int_save = 1'b0, rti_restore = 1'b0;
    logic [3:0]    flags;
    logic [CW-1:0] depth_count;
    logic          stack_full, stack_empty, ovf_err, unf_err;

    typedef struct packed {
        logic [3:0]    fl;
        logic [CW-1:0] dp;
        logic          ov;
        logic          un;
    } exp_t;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_vec = 0;
    int    n_bad = 0;

    ccr_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .z_en(z_en), .n_en(n_en), .c_en(c_en), .v_en(v_en),
        .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
        .jz_taken(jz_taken), .jn_taken(jn_taken), .jc_taken(jc_taken), .jv_taken(jv_taken),
        .int_save(int_save), .rti_restore(rti_restore),
        .flags(flags), .depth_count(depth_count),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [7:0] got, input logic [7:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, want);
        end
    endtask

    // Monitor: one expected entry per driven cycle, compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            chk(nm, "flags", {4'b0000, flags}, {4'b0000, e.fl});
            chk(nm, "depth", 8'(depth_count), 8'(e.dp));
            chk(nm, "full",  {7'b0, stack_full},  {7'b0, (e.dp == CW'(DEPTH))});
            chk(nm, "empty", {7'b0, stack_empty}, {7'b0, (e.dp == CW'(0))});
            chk(nm, "ovf",   {7'b0, ovf_err}, {7'b0, e.ov});
            chk(nm, "unf",   {7'b0, unf_err}, {7'b0, e.un});
        end
    end

    // en/alu/clr vectors are ordered {V,C,N,Z}.
    task automatic step(input string nm, input logic r, input logic s,
                        input logic [3:0] en, input logic [3:0] alu, input logic [3:0] clr,
                        input logic sv, input logic rt,
                        input logic [3:0] ef, input int ed, input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s;
        {v_en, c_en, n_en, z_en} = en;
        {alu_v, alu_c, alu_n, alu_z} = alu;
        {jv_taken, jc_taken, jn_taken, jz_taken} = clr;
        int_save = sv; rti_restore = rt;
        e.fl = ef; e.dp = CW'(ed); e.ov = eo; e.un = eu;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        step("reset",      1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        step("idle",       1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        step("load_all",   1'b0, 1'b0, 4'b1111, 4'b1101, 4'b0000, 1'b0, 1'b0, 4'b1101, 0, 1'b0, 1'b0);
        step("load_c",     1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1001, 0, 1'b0, 1'b0);
        step("set_all",    1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1111, 0, 1'b0, 1'b0);
        step("clr_wins",   1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b1110, 0, 1'b0, 1'b0);
        step("jc_clear",   1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b1010, 0, 1'b0, 1'b0);
        step("reset2",     1'b1, 1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        // Nesting: push carries the same-cycle update into the saved entry.
        step("push_upd",   1'b0, 1'b0, 4'b1111, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b0011, 1, 1'b0, 1'b0);
        step("upd_0100",   1'b0, 1'b0, 4'b1111, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1, 1'b0, 1'b0);
        step("push2",      1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0100, 2, 1'b0, 1'b0);
        step("upd_1000",   1'b0, 1'b0, 4'b1111, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 2, 1'b0, 1'b0);
        step("pop1_ignup", 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0100, 1, 1'b0, 1'b0);
        step("pop2",       1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0011, 0, 1'b0, 1'b0);
        step("both_empty", 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0111, 0, 1'b0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            step("fill",   1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0111, i, 1'b0, 1'b0);
        end
        step("push_full",  1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 4'b0110, DEPTH, 1'b1, 1'b0);
        step("both_full",  1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0110, DEPTH, 1'b1, 1'b0);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            step("drain",  1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0111, i, 1'b1, 1'b0);
        end
        step("pop_empty",  1'b0, 1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b1, 4'b1111, 0, 1'b1, 1'b1);
        step("stall_hold", 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b1111, 0, 1'b1, 1'b1);
        step("stall_hold2",1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b1111, 0, 1'b1, 1'b1);
        step("unstall",    1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b1, 1'b0, 4'b0000, 1, 1'b1, 1'b1);
        step("rst_stall",  1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        step("post_rst",   1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; int_save = 1'b0; rti_restore = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
